// File: rtl/Modules_pkg.sv
// Shared FP types: float_t, fcmp_ops, fcmp_req_t and fp_flags_t.
// Used by the FMIN/FMAX issue controller and its result FIFO.
// Purely declarative: no ports, no logic.
package Modules_pkg;

  typedef logic [31:0] float_t;

  typedef enum logic {
    FMIN_ = 1'b0,
    FMAX_ = 1'b1
  } fcmp_ops;

  // Default destination tag width carried in fcmp_req_t.
  localparam int FCMP_TAG_W = 5;

  typedef struct packed {
    float_t                  operand_a;
    float_t                  operand_b;
    fcmp_ops                 operation;
    logic [FCMP_TAG_W-1:0]   tag;
  } fcmp_req_t;

  // IEEE exception flags in CSR order {NV, OF, UF}.
  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
  } fp_flags_t;

endpackage

// File: rtl/fp_cmp_result_fifo.sv
// Synchronous FIFO for magnitude-unit results, with an occupancy count.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: none internally; the caller guarantees no push when full.
// Ports: clk_i, rst_i (sync, active-high), push_vld/push_dat, pop,
//        head_vld/head_dat (zero while empty), count.
module fp_cmp_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic                       head_vld,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset; the head is masked while empty instead.
  always_ff @(posedge clk_i) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({push_vld, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_vld = (count != '0);
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fp_mag_issue_ctrl.sv
// Round-robin issue control for the FMIN/FMAX unit with result FIFO and sticky flags.
// Latency: accept in N, unit result captured end of N+1, result_valid_o in N+2.
// Backpressure: credit = FIFO room minus in-flight op; ready drops when exhausted.
// Ports: two request ports (valid/ready, operands, operation, tag), unit drive
//        (operands, operation, clk_en, rst_n) and capture (result, flags),
//        result FIFO head (valid/ready, result, tag, port, flags), sticky flags
//        with clear, busy.
module fp_mag_issue_ctrl
  import Modules_pkg::*;
#(
  parameter int TAG_W      = FCMP_TAG_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  float_t           req0_op_a_i,
  input  float_t           req0_op_b_i,
  input  fcmp_ops          req0_operation_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  float_t           req1_op_a_i,
  input  float_t           req1_op_b_i,
  input  fcmp_ops          req1_operation_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output float_t           unit_operand_A_o,
  output float_t           unit_operand_B_o,
  output fcmp_ops          unit_operation_o,
  output logic             unit_clk_en_o,
  output logic             unit_rst_n_o,
  input  float_t           unit_result_i,
  input  logic             unit_invalid_i,
  input  logic             unit_overflow_i,
  input  logic             unit_underflow_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output float_t           result_o,
  output logic [TAG_W-1:0] result_tag_o,
  output logic             result_port_o,
  output logic [2:0]       result_flags_o,
  output logic [2:0]       sticky_flags_o,
  input  logic             flags_clear_i,
  output logic             busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = 1 + 3 + TAG_W + 32;

  logic             rr_q;
  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_port;
  fp_flags_t        sticky_q;

  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credit_use;
  logic             can_issue;
  logic             pop;
  logic             grant0, grant1;
  logic             accept0, accept1, issue;
  fcmp_req_t        req0_pkt, req1_pkt, sel_pkt;
  fp_flags_t        flags_in;
  logic [PW-1:0]    head_dat;

  assign pop = result_valid_o & result_ready_i;

  // Entries already owed FIFO space: stored ones plus the one in the unit,
  // minus the one leaving this cycle. Pop implies count >= 1, so no underflow.
  assign credit_use = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid} - {{CW{1'b0}}, pop};
  assign can_issue  = credit_use < (CW+1)'(FIFO_DEPTH);

  // rr names the port that wins a tie.
  assign grant0 = req0_valid_i & (~req1_valid_i | ~rr_q);
  assign grant1 = req1_valid_i & (~req0_valid_i |  rr_q);

  assign accept0 = can_issue & grant0 & ~rst_i;
  assign accept1 = can_issue & grant1 & ~rst_i;
  assign issue   = accept0 | accept1;

  assign req0_ready_o = accept0;
  assign req1_ready_o = accept1;

  // A TAG_W differing from the package default is resized at the struct boundary.
  always_comb begin
    req0_pkt           = '0;
    req0_pkt.operand_a = req0_op_a_i;
    req0_pkt.operand_b = req0_op_b_i;
    req0_pkt.operation = req0_operation_i;
    req0_pkt.tag       = FCMP_TAG_W'(req0_tag_i);
    req1_pkt           = '0;
    req1_pkt.operand_a = req1_op_a_i;
    req1_pkt.operand_b = req1_op_b_i;
    req1_pkt.operation = req1_operation_i;
    req1_pkt.tag       = FCMP_TAG_W'(req1_tag_i);
  end

  assign sel_pkt          = grant1 ? req1_pkt : req0_pkt;
  assign unit_operand_A_o = sel_pkt.operand_a;
  assign unit_operand_B_o = sel_pkt.operand_b;
  assign unit_operation_o = sel_pkt.operation;
  assign unit_clk_en_o    = issue;
  assign unit_rst_n_o     = ~rst_i;

  always_comb begin
    flags_in    = '0;
    flags_in.nv = unit_invalid_i;
    flags_in.of = unit_overflow_i;
    flags_in.uf = unit_underflow_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= 1'b0;
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_port  <= 1'b0;
      sticky_q <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        rr_q    <= accept0;
        s1_tag  <= TAG_W'(sel_pkt.tag);
        s1_port <= accept1;
      end
      // Clear first, then OR in the flags being written this cycle.
      if (s1_valid)           sticky_q <= (flags_clear_i ? '0 : sticky_q) | flags_in;
      else if (flags_clear_i) sticky_q <= '0;
    end
  end

  fp_cmp_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PW)
  ) u_result_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (s1_valid),
    .push_dat ({s1_port, flags_in, s1_tag, unit_result_i}),
    .pop      (pop),
    .head_vld (result_valid_o),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  assign {result_port_o, result_flags_o, result_tag_o, result_o} = head_dat;

  assign sticky_flags_o = sticky_q;
  assign busy_o         = s1_valid | result_valid_o;

endmodule

// File: tb/tb_fp_mag_issue_ctrl.sv
module tb_fp_mag_issue_ctrl;
  import Modules_pkg::*;

  localparam int TAG_W = 5;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, res_rdy, clr;
  logic             pv [2];
  float_t           pa [2];
  float_t           pb [2];
  fcmp_ops          pop_op [2];
  logic [TAG_W-1:0] ptag [2];

  logic             ready0, ready1;
  float_t           u_a, u_b, u_res;
  fcmp_ops          u_op;
  logic             u_en, u_rst_n;
  logic [2:0]       u_flags;
  logic             r_vld, r_port, busy;
  float_t           r_res;
  logic [TAG_W-1:0] r_tag;
  logic [2:0]       r_flags, sticky;

  fp_mag_issue_ctrl #(.TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(pv[0]), .req0_ready_o(ready0), .req0_op_a_i(pa[0]), .req0_op_b_i(pb[0]),
    .req0_operation_i(pop_op[0]), .req0_tag_i(ptag[0]),
    .req1_valid_i(pv[1]), .req1_ready_o(ready1), .req1_op_a_i(pa[1]), .req1_op_b_i(pb[1]),
    .req1_operation_i(pop_op[1]), .req1_tag_i(ptag[1]),
    .unit_operand_A_o(u_a), .unit_operand_B_o(u_b), .unit_operation_o(u_op),
    .unit_clk_en_o(u_en), .unit_rst_n_o(u_rst_n), .unit_result_i(u_res),
    .unit_invalid_i(u_flags[2]), .unit_overflow_i(u_flags[1]), .unit_underflow_i(u_flags[0]),
    .result_valid_o(r_vld), .result_ready_i(res_rdy), .result_o(r_res), .result_tag_o(r_tag),
    .result_port_o(r_port), .result_flags_o(r_flags), .sticky_flags_o(sticky),
    .flags_clear_i(clr), .busy_o(busy)
  );

  // ---------------- floating-point reference behaviour ----------------
  function automatic bit is_nan(input float_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction
  function automatic bit is_inf(input float_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction
  function automatic bit f_lt(input float_t a, input float_t b);
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction
  function automatic float_t fmag(input float_t a, input float_t b, input fcmp_ops op);
    if (is_nan(a) && is_nan(b)) return 32'h7FC00000;
    if (is_nan(a)) return b;
    if (is_nan(b)) return a;
    if (op == FMIN_) return f_lt(a, b) ? a : b;
    return f_lt(a, b) ? b : a;
  endfunction
  function automatic logic [2:0] fflags(input float_t a, input float_t b, input fcmp_ops op);
    float_t r;
    r = fmag(a, b, op);
    return {is_nan(a) | is_nan(b), is_inf(r), is_inf(a) & is_inf(b)};
  endfunction

  // Behavioural magnitude unit: one register stage gated by the clock enable.
  always_ff @(posedge clk) begin
    if (!u_rst_n) begin
      u_res   <= '0;
      u_flags <= '0;
    end else if (u_en) begin
      u_res   <= fmag(u_a, u_b, u_op);
      u_flags <= fflags(u_a, u_b, u_op);
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    float_t           res;
    logic [TAG_W-1:0] tag;
    logic             port;
    logic [2:0]       flags;
    int               vis;
  } ent_t;

  ent_t       q[$];
  int         acc_log[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_acc0 = 0;
  logic       m_rr = 1'b0;
  logic [2:0] m_sticky = 3'b000;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int p, input float_t a, input float_t b, input fcmp_ops op,
                         input logic [TAG_W-1:0] tag);
    pv[p] = 1'b1; pa[p] = a; pb[p] = b; pop_op[p] = op; ptag[p] = tag;
  endtask

  // One clock: check outputs at the falling edge against the model, then
  // advance the model across the rising edge.
  task automatic step();
    bit   exp_vld, popx, can, a0, a1;
    int   g, p;
    ent_t e;
    logic [2:0] nf;
    a0 = 0; a1 = 0; popx = 0;
    @(negedge clk);
    if (rst) begin
      check_eq("rst_ready0", ready0, 0);
      check_eq("rst_ready1", ready1, 0);
      check_eq("rst_unit_rst_n", u_rst_n, 0);
    end else begin
      exp_vld = (q.size() > 0) && (q[0].vis <= cyc);
      popx    = exp_vld && res_rdy;
      can     = (q.size() - int'(popx)) < DEPTH;
      g = -1;
      if (pv[0] && pv[1]) g = int'(m_rr);
      else if (pv[0])     g = 0;
      else if (pv[1])     g = 1;
      a0 = can && (g == 0);
      a1 = can && (g == 1);
      check_eq("ready0", ready0, a0);
      check_eq("ready1", ready1, a1);
      check_eq("unit_clk_en", u_en, a0 | a1);
      check_eq("unit_rst_n", u_rst_n, 1);
      check_eq("result_valid", r_vld, exp_vld);
      check_eq("busy", busy, q.size() > 0);
      check_eq("sticky", sticky, m_sticky);
      if (exp_vld) begin
        check_eq("result", r_res, q[0].res);
        check_eq("result_tag", r_tag, q[0].tag);
        check_eq("result_port", r_port, q[0].port);
        check_eq("result_flags", r_flags, q[0].flags);
      end
      if (ready0 && pv[0]) begin acc_log.push_back(0); n_acc0++; end
      if (ready1 && pv[1]) acc_log.push_back(1);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_rr = 1'b0;
      m_sticky = 3'b000;
    end else begin
      if (popx) void'(q.pop_front());
      if (a0 || a1) begin
        p = a1 ? 1 : 0;
        e.res   = fmag(pa[p], pb[p], pop_op[p]);
        e.flags = fflags(pa[p], pb[p], pop_op[p]);
        e.tag   = ptag[p];
        e.port  = a1;
        e.vis   = cyc + 2;
        q.push_back(e);
        m_rr  = a0;
        pv[p] = 1'b0;
      end
      nf = 3'b000;
      foreach (q[i]) if (q[i].vis == cyc + 1) nf = nf | q[i].flags;
      m_sticky = (clr ? 3'b000 : m_sticky) | nf;
    end
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    res_rdy = 1'b1;
    while ((q.size() > 0 || pv[0] || pv[1]) && n < 50) begin
      step();
      n++;
    end
    check_eq("drain_within_bound", n < 50, 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic float_t rnd_fp();
    float_t x;
    case ($urandom_range(0, 7))
      0: x = 32'h7F800000;
      1: x = 32'hFF800000;
      2: x = 32'h7FC00000;
      3: x = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h00000000;
      default: x = $urandom & 32'hBFFFFFFF;
    endcase
    return x;
  endfunction

  int n0;

  initial begin
    rst = 1'b1; res_rdy = 1'b1; clr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pv[p] = 1'b0; pa[p] = '0; pb[p] = '0; pop_op[p] = FMIN_; ptag[p] = '0;
    end

    // Reset state
    step(); step();
    rst = 1'b0;
    check_eq("reset_result_valid", r_vld, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_sticky", sticky, 0);
    check_eq("reset_result", r_res, 0);
    check_eq("reset_tag", r_tag, 0);
    check_eq("reset_port", r_port, 0);
    check_eq("reset_flags", r_flags, 0);
    check_eq("reset_clk_en", u_en, 0);

    // Single op, two-cycle latency
    set_req(0, 32'h3F800000, 32'h40000000, FMIN_, 5'd3);
    step();
    check_eq("single_not_yet_valid", r_vld, 0);
    step();
    check_eq("single_valid", r_vld, 1);
    check_eq("single_result", r_res, 32'h3F800000);
    check_eq("single_tag", r_tag, 3);
    check_eq("single_port", r_port, 0);
    drain();

    // Contention: alternate grants starting at port 0 after reset
    pulse_reset();
    acc_log.delete();
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pv[p]) set_req(p, rnd_fp(), rnd_fp(), FMAX_, 5'(8 * p + i));
      step();
    end
    check_eq("contention_grant_count", acc_log.size(), 4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      check_eq($sformatf("contention_grant%0d", i), acc_log[i], i % 2);
    pv[0] = 1'b0; pv[1] = 1'b0;
    drain();

    // Backpressure: only DEPTH accepts while the consumer stalls
    res_rdy = 1'b0;
    n0 = n_acc0;
    for (int i = 0; i < 8; i++) begin
      if (!pv[0]) set_req(0, rnd_fp(), rnd_fp(), FMIN_, 5'(i + 10));
      step();
    end
    check_eq("backpressure_accepts", n_acc0 - n0, 2);
    drain();

    // Flags: -inf,-inf produces {OF,UF}; clear; clear coincident with write
    res_rdy = 1'b0;
    set_req(0, 32'hFF800000, 32'hFF800000, FMAX_, 5'd7);
    step(); step();
    check_eq("flags_result", r_res, 32'hFF800000);
    check_eq("flags_head", r_flags, 3'b011);
    check_eq("flags_sticky", sticky, 3'b011);
    clr = 1'b1; step(); clr = 1'b0;
    check_eq("flags_cleared", sticky, 3'b000);
    set_req(0, 32'hFF800000, 32'hFF800000, FMAX_, 5'd9);
    step();
    clr = 1'b1; step(); clr = 1'b0;
    check_eq("flags_clear_with_write", sticky, 3'b011);
    drain();

    // Reset with one op queued and one in flight
    res_rdy = 1'b0;
    set_req(0, 32'hFF800000, 32'hFF800000, FMAX_, 5'd1);
    step();
    set_req(0, 32'h3F800000, 32'hBF800000, FMIN_, 5'd2);
    step();
    check_eq("midop_busy_before", busy, 1);
    set_req(0, 32'h40400000, 32'h40000000, FMAX_, 5'd4);
    set_req(1, 32'h40400000, 32'h40000000, FMIN_, 5'd5);
    pulse_reset();
    check_eq("midop_result_valid", r_vld, 0);
    check_eq("midop_busy", busy, 0);
    check_eq("midop_sticky", sticky, 0);
    res_rdy = 1'b1;
    n0 = acc_log.size();
    step();
    check_eq("midop_next_grant_logged", acc_log.size() > n0, 1);
    if (acc_log.size() > n0) check_eq("midop_next_grant_port", acc_log[n0], 0);
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pv[p] && $urandom_range(0, 1) == 1)
          set_req(p, rnd_fp(), rnd_fp(), ($urandom_range(0, 1) == 1) ? FMAX_ : FMIN_,
                  TAG_W'($urandom));
      res_rdy = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 9) == 0);
      step();
    end
    clr = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
